// File: rtl/gpio_debounce.sv
`timescale 1ns/1ps
// gpio_debounce
//   Conditions raw asynchronous GPIO pins for the system controller's input
//   bus: two-flop synchroniser per channel, then per-channel stability
//   counting on a shared prescaled sample tick.
//
// Ports:
//   sys_clk       system clock
//   sys_rst_n     asynchronous active-low reset
//   gpio_raw      raw asynchronous pins
//   gpio_clean    debounced levels (registered)
//   gpio_changed  one-cycle pulse per channel when gpio_clean toggles
//   tick          one-cycle sample-tick strobe
module gpio_debounce #(
  parameter int unsigned         ninputs     = 16,
  parameter int unsigned         prescale    = 1000,
  parameter int unsigned         threshold   = 20,
  parameter logic [ninputs-1:0]  reset_level = '0
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [ninputs-1:0] gpio_raw,
  output logic [ninputs-1:0] gpio_clean,
  output logic [ninputs-1:0] gpio_changed,
  output logic               tick
);

  localparam int unsigned PW = (prescale  > 1) ? $clog2(prescale)  : 1;
  localparam int unsigned CW = (threshold > 1) ? $clog2(threshold) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(prescale - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(threshold - 1);

  logic [ninputs-1:0] sync1_q, sync1_d;
  logic [ninputs-1:0] sync2_q, sync2_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic               tick_q, tick_d;
  logic [ninputs-1:0] clean_q, clean_d;
  logic [ninputs-1:0] changed_q, changed_d;
  logic [CW-1:0]      cnt_q [ninputs];
  logic [CW-1:0]      cnt_d [ninputs];

  // Synchroniser and prescaler. tick_q is registered from the next
  // prescaler value so it is high exactly while pre_q == prescale-1,
  // yet still comes out of reset as 0.
  always_comb begin
    sync1_d = gpio_raw;
    sync2_d = sync1_q;
    pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    tick_d  = (pre_d == PRE_LAST);
  end

  // Per-channel stability counting. A sample that agrees with the
  // current clean level restarts the count, so a single glitch sample
  // wipes out any partial progress.
  always_comb begin
    clean_d   = clean_q;
    changed_d = '0;
    for (int unsigned i = 0; i < ninputs; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i]   = sync2_q[i];
          changed_d[i] = 1'b1;
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= reset_level;
      sync2_q   <= reset_level;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      clean_q   <= reset_level;
      changed_q <= '0;
      for (int unsigned i = 0; i < ninputs; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
      for (int unsigned i = 0; i < ninputs; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gpio_clean   = clean_q;
  assign gpio_changed = changed_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_gpio_debounce.sv
`timescale 1ns/1ps
// Directed testbench for gpio_debounce: one instance with prescale=4,
// threshold=3 and one with the degenerate prescale=1, threshold=1.
module tb_gpio_debounce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] raw, raw_deg;
  logic [15:0] clean, changed, clean_deg, changed_deg;
  logic        tick, tick_deg;

  int errors = 0;
  int checks = 0;
  int pulses [16];
  int n;
  int total;
  logic [15:0] pv;

  always #5 clk = ~clk;

  gpio_debounce #(
    .ninputs(16), .prescale(4), .threshold(3), .reset_level(16'h0000)
  ) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .gpio_raw(raw),
    .gpio_clean(clean), .gpio_changed(changed), .tick(tick)
  );

  gpio_debounce #(
    .ninputs(16), .prescale(1), .threshold(1), .reset_level(16'h0000)
  ) u_deg (
    .sys_clk(clk), .sys_rst_n(rst_n), .gpio_raw(raw_deg),
    .gpio_clean(clean_deg), .gpio_changed(changed_deg), .tick(tick_deg)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (changed[i] === 1'b1) pulses[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 16; i++) pulses[i] = 0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    raw     = '0;
    raw_deg = '0;
    cyc(2);
    clear_pulses();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    raw     = '0;
    raw_deg = '0;
    clear_pulses();
    cyc(2);
    rst_n = 1'b1;

    // Tick period after release: high on edges 3, 7 (prescaler == 3).
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      check("tick_phase", tick, (k % 4 == 3) ? 1 : 0);
    end

    // Asynchronous reset mid-cycle while raw is all ones.
    raw = 16'hFFFF;
    cyc(20);
    check("pre_rst_clean", clean, 16'hFFFF);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_clean", clean, 16'h0000);
    check("rst_async_changed", changed, 16'h0000);
    check("rst_async_tick", tick, 0);
    raw = '0;
    cyc(2);
    clear_pulses();
    rst_n = 1'b1;

    // Clean edge on channel 0: accepted 11..14 edges after the raw edge.
    cyc(5);
    raw = 16'h0001;
    n = 0;
    while (n < 30 && clean[0] !== 1'b1) begin
      cyc(1);
      n++;
    end
    check("edge_found", clean[0], 1);
    check("edge_latency_in_11_14", (n >= 11 && n <= 14), 1);
    check("edge_changed", changed, 16'h0001);
    check("edge_clean", clean, 16'h0001);
    cyc(1);
    check("edge_changed_drop", changed, 16'h0000);
    cyc(10);
    check("edge_clean_hold", clean, 16'h0001);
    total = 0;
    for (int i = 1; i < 16; i++) total += pulses[i];
    check("edge_pulses_ch0", pulses[0], 1);
    check("edge_pulses_other", total, 0);

    // Glitch on channel 5: 6 cycles high spans at most 2 ticks.
    do_reset();
    cyc(3);
    raw = 16'h0020;
    cyc(6);
    raw = 16'h0000;
    cyc(30);
    check("glitch_clean", clean, 16'h0000);
    check("glitch_pulses", pulses[5], 0);

    // Bounce on channel 3: toggles every 5 cycles for 40 cycles, then 1.
    do_reset();
    cyc(3);
    for (int k = 0; k < 8; k++) begin
      raw[3] = (k % 2 == 0);
      cyc(5);
    end
    check("bounce_no_pulse_yet", pulses[3], 0);
    check("bounce_clean_low", clean, 16'h0000);
    raw[3] = 1'b1;
    n = 0;
    while (n < 30 && clean[3] !== 1'b1) begin
      cyc(1);
      n++;
    end
    check("bounce_settled", clean, 16'h0008);
    cyc(20);
    check("bounce_one_pulse", pulses[3], 1);

    // Simultaneous channels.
    do_reset();
    cyc(3);
    raw = 16'hA5A5;
    n = 0;
    while (n < 30 && clean === 16'h0000) begin
      cyc(1);
      n++;
    end
    check("simul_clean", clean, 16'hA5A5);
    check("simul_changed", changed, 16'hA5A5);
    cyc(1);
    check("simul_changed_drop", changed, 16'h0000);
    check("simul_clean_hold", clean, 16'hA5A5);
    for (int i = 0; i < 16; i++) pv[i] = (pulses[i] == 1);
    check("simul_pulse_map", pv, 16'hA5A5);

    // Degenerate prescale=1, threshold=1: toggle 3 edges after raw.
    do_reset();
    cyc(3);
    raw_deg = 16'h0001;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("deg_clean", clean_deg, (k >= 3) ? 16'h0001 : 16'h0000);
      check("deg_changed", changed_deg, (k == 3) ? 16'h0001 : 16'h0000);
    end

    // Reset one cycle after a raw edge: no toggle, then full re-debounce.
    do_reset();
    cyc(3);
    raw_deg = 16'h0002;
    cyc(1);
    rst_n = 1'b0;
    #1;
    check("deg_rst_clean", clean_deg, 16'h0000);
    cyc(2);
    check("deg_rst_clean_hold", clean_deg, 16'h0000);
    check("deg_rst_changed", changed_deg, 16'h0000);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check("deg_redebounce", clean_deg, (k >= 3) ? 16'h0002 : 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
